// File: rtl/button_pkg.sv
// Shared types and widths for the push-button debouncer.
// Holds the FSM state encoding and the event/drop/timestamp widths.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int EV_DATA_W = 8;
  localparam int DROP_W    = 8;
  localparam int TS_W      = 16;

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchronizer for one asynchronous level, reset to 0.
// Ports: clk, rst (async, active-low), d (async in), q (synced out).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer with a one-deep press-event holding register.
// Ports: clk, rst (async, active-low), button (raw level in),
//   btn_level (debounced level), ev_valid/ev_ready/ev_data (press
//   sequence number handshake), drop_cnt (presses lost, saturating).
// Option BUTTON_DEBOUNCE_TIMESTAMP_EN adds ev_time, a 16-bit cycle
//   stamp captured when the press is committed.
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 button,
  output logic                 btn_level,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [EV_DATA_W-1:0] ev_data,
  output logic [DROP_W-1:0]    drop_cnt
`ifdef BUTTON_DEBOUNCE_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]      ev_time
`endif
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_sync;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             commit;
  logic             accept;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button),
    .q   (btn_sync)
  );

  assign cnt_inc = cnt + 1'b1;

  // The sample that moves IDLE->PRESS_WAIT is the first stable one,
  // so the wait states finish when the incremented count hits LAST.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn_sync) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == LAST) begin
            state_nxt = PRESSED;
            commit    = 1'b1;
          end
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_nxt = PRESSED;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == LAST) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign btn_level = (state == PRESSED) ||
                     (state == RELEASE_WAIT);

  // The holding register takes a new press when empty or when the
  // current one is being handed off in the same cycle.
  assign accept = commit && (!ev_valid || ev_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev_valid <= 1'b0;
      ev_data  <= '0;
      drop_cnt <= '0;
    end else if (accept) begin
      ev_valid <= 1'b1;
      ev_data  <= ev_data + 1'b1;
    end else begin
      if (ev_ready) begin
        ev_valid <= 1'b0;
      end
      if (commit && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

`ifdef BUTTON_DEBOUNCE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_cnt  <= '0;
      ev_time <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (accept) begin
        ev_time <= ts_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (DEBOUNCE_CYCLES=4).
// Expected presses go into a scoreboard, popped on each handshake.
module tb_button_debounce;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       button = 1'b0;
  logic       ev_ready = 1'b0;
  logic       btn_level;
  logic       ev_valid;
  logic [7:0] ev_data;
  logic [7:0] drop_cnt;
`ifdef BUTTON_DEBOUNCE_TIMESTAMP_EN
  logic [15:0] ev_time;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int time_q[$];
  logic [7:0] seq = 8'd0;

  button_debounce #(
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .button    (button),
    .btn_level (btn_level),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_data   (ev_data),
    .drop_cnt  (drop_cnt)
`ifdef BUTTON_DEBOUNCE_TIMESTAMP_EN
    ,
    .ev_time   (ev_time)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, int obs, int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    button = 1'b0;
    step(2);
    rst = 1'b1;
    seq = 8'd0;
  endtask

  task automatic expect_ev(int t);
    seq++;
    exp_q.push_back(int'(seq));
    time_q.push_back(t);
  endtask

  task automatic press(int hold, int gap, bit ev);
    if (ev) expect_ev(-1);
    button = 1'b1;
    step(hold);
    button = 1'b0;
    step(gap);
  endtask

  // Handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (rst && ev_valid && ev_ready) begin
      int d;
      int t;
      chk("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        d = exp_q.pop_front();
        t = time_q.pop_front();
        chk("sb_data", int'(ev_data), d);
`ifdef BUTTON_DEBOUNCE_TIMESTAMP_EN
        if (t >= 0) chk("sb_time", int'(ev_time), t);
`endif
      end
    end
  end

  initial begin
    // Reset and quiet idle
    step(1);
    chk("rst_lvl", int'(btn_level), 0);
    chk("rst_val", int'(ev_valid), 0);
    chk("rst_data", int'(ev_data), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    step(1);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("idle_out",
          int'({btn_level, ev_valid, ev_data, drop_cnt}), 0);
    end

    // Clean press, ready high: 6-cycle latency, 1-cycle valid
    ev_ready = 1'b1;
    expect_ev(-1);
    button = 1'b1;
    step(5);
    chk("p1_lvl_early", int'(btn_level), 0);
    chk("p1_val_early", int'(ev_valid), 0);
    step(1);
    chk("p1_lvl", int'(btn_level), 1);
    chk("p1_val", int'(ev_valid), 1);
    chk("p1_data", int'(ev_data), 1);
    step(1);
    chk("p1_val_1cyc", int'(ev_valid), 0);
    step(3);
    button = 1'b0;
    step(5);
    chk("p1_lvl_hold", int'(btn_level), 1);
    step(1);
    chk("p1_lvl_fall", int'(btn_level), 0);
    step(4);

    // Glitch of 3 cycles: nothing happens
    button = 1'b1;
    step(3);
    button = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("gl_lvl", int'(btn_level), 0);
      chk("gl_val", int'(ev_valid), 0);
    end
    // Back in IDLE: next press has full latency
    expect_ev(-1);
    button = 1'b1;
    step(5);
    chk("gl_next_early", int'(btn_level), 0);
    step(1);
    chk("gl_next_lvl", int'(btn_level), 1);
    chk("gl_next_data", int'(ev_data), 2);
    step(4);
    button = 1'b0;
    step(8);

    // Backpressure: second press dropped
    do_reset();
    ev_ready = 1'b0;
    press(8, 8, 1'b1);
    chk("bp_val", int'(ev_valid), 1);
    chk("bp_data", int'(ev_data), 1);
    button = 1'b1;
    step(6);
    chk("bp_drop", int'(drop_cnt), 1);
    chk("bp_data_hold", int'(ev_data), 1);
    chk("bp_val_hold", int'(ev_valid), 1);
    button = 1'b0;
    step(8);
    ev_ready = 1'b1;
    step(1);
    chk("bp_val_clr", int'(ev_valid), 0);

    // Release bounce: level stays up, no second event
    expect_ev(-1);
    button = 1'b1;
    step(10);
    button = 1'b0;
    step(1);
    chk("rb_lvl0", int'(btn_level), 1);
    step(1);
    chk("rb_lvl1", int'(btn_level), 1);
    button = 1'b1;
    step(1);
    chk("rb_lvl2", int'(btn_level), 1);
    button = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("rb_lvl_hold", int'(btn_level), 1);
      chk("rb_val", int'(ev_valid), 0);
    end
    step(1);
    chk("rb_lvl_fall", int'(btn_level), 0);
    step(10);
    chk("rb_data", int'(ev_data), 2);
    chk("rb_drop", int'(drop_cnt), 1);

    // Drop counter saturation
    do_reset();
    ev_ready = 1'b0;
    press(8, 8, 1'b1);
    repeat (256) press(8, 8, 1'b0);
    chk("sat_drop", int'(drop_cnt), 255);
    chk("sat_data", int'(ev_data), 1);
    ev_ready = 1'b1;
    step(1);
    chk("sat_val_clr", int'(ev_valid), 0);

    // Sequence number wraps 255 -> 0
    do_reset();
    ev_ready = 1'b1;
    repeat (256) press(8, 8, 1'b1);
    chk("wrap_data", int'(ev_data), int'(seq));
    chk("wrap_zero", int'(ev_data), 0);
    chk("wrap_drop", int'(drop_cnt), 0);

    // Reset mid PRESS_WAIT with an event pending
    do_reset();
    ev_ready = 1'b0;
    press(8, 8, 1'b0);
    button = 1'b1;
    step(4);
    rst = 1'b0;
    step(1);
    chk("mr_val", int'(ev_valid), 0);
    chk("mr_data", int'(ev_data), 0);
    chk("mr_drop", int'(drop_cnt), 0);
    chk("mr_lvl", int'(btn_level), 0);
    step(1);
    rst = 1'b1;
    ev_ready = 1'b1;
    seq = 8'd0;
    // Commit lands in the 6th cycle after release; counter starts at 0
    expect_ev(5);
    step(5);
    chk("mr_lvl_early", int'(btn_level), 0);
    step(1);
    chk("mr_lvl_up", int'(btn_level), 1);
    chk("mr_val_up", int'(ev_valid), 1);
    chk("mr_data_up", int'(ev_data), 1);
    button = 1'b0;
    step(10);

    chk("sb_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
